sd_cmd_serial_host: RTL

//  Serial CMD-line engine downstream of the command master. Takes a 40-bit command
//  (cmd_in + settings) over a req/ack handshake and shifts it onto the SD CMD pin with
//  CRC7 and end bit. Captures the card response and reports it back as status + 40-bit

---
 rtl/sd_cmd_serial_host_pkg.sv | 50 +++++
 rtl/sd_crc7_serial.sv | 25 ++
 rtl/sd_cmd_serial_host.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_cmd_serial_host_pkg.sv
// Shared definitions for the SD CMD-line serial engine: one-hot state codes,
// status bit positions, response sizes, frame lengths and the CRC7 step.
package sd_cmd_serial_host_pkg;

    // One-hot state encoding; the same value is exported on the debug port.
    typedef enum logic [6:0] {
        ST_INIT     = 7'b000_0001,
        ST_IDLE     = 7'b000_0010,
        ST_WRITE    = 7'b000_0100,
        ST_DLY      = 7'b000_1000,
        ST_WAIT_RSP = 7'b001_0000,
        ST_READ     = 7'b010_0000,
        ST_FINISH   = 7'b100_0000
    } state_t;

    // serial_status bit positions
    localparam int STATUS_DAT_AVA   = 6;
    localparam int STATUS_CRC_VALID = 5;
    localparam int STATUS_BUSY      = 0;

    // Response size codes carried in settings[6:0]
    localparam logic [6:0] RESP_SHORT = 7'd40;
    localparam logic [6:0] RESP_LONG  = 7'd127;

    // Command frame: 40 command bits, 7 CRC bits, 1 end bit
    localparam logic [7:0] CMD_BITS      = 8'd40;
    localparam logic [7:0] CMD_LAST      = 8'd47;

    // Response frames: index of the first protected bit, first CRC bit, last bit
    localparam logic [7:0] SHORT_DATA_FIRST = 8'd0;
    localparam logic [7:0] SHORT_CRC_FIRST  = 8'd40;
    localparam logic [7:0] SHORT_LAST       = 8'd47;
    localparam logic [7:0] LONG_DATA_FIRST  = 8'd8;
    localparam logic [7:0] LONG_CRC_FIRST   = 8'd128;
    localparam logic [7:0] LONG_LAST        = 8'd135;

    // Bits 0..39 of any response land in cmd_out
    localparam logic [7:0] CAPTURE_BITS = 8'd40;

    // CRC7 generator polynomial x^7 + x^3 + 1 (implicit x^7)
    localparam logic [6:0] CRC7_POLY = 7'h09;

    // One serial CRC7 step, bits presented MSB first
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = crc[6] ^ bit_in;
        crc7_step = {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7_serial.sv
// Bit-serial CRC7 accumulator. clear has priority over enable; the value
// holds whenever enable is low so the result can be read after the last bit.
module sd_crc7_serial
    import sd_cmd_serial_host_pkg::*;
(
    input  logic       CLK_PAD_IO,
    input  logic       RST_PAD_I,
    input  logic       bit_in,
    input  logic       enable,
    input  logic       clear,
    output logic [6:0] crc
);

    // Accumulate one bit per enabled cycle
    always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
        if (RST_PAD_I) begin
            crc <= 7'd0;
        end else if (clear) begin
            crc <= 7'd0;
        end else if (enable) begin
            crc <= crc7_step(crc, bit_in);
        end
    end

endmodule

// File: rtl/sd_cmd_serial_host.sv
// SD CMD-line serial engine. Shifts a 40-bit command plus CRC7 and end bit
// onto the CMD pin, then captures the card response and reports status.
//
// Handshakes (both level based, both inputs pass a 2-FF synchroniser):
//   command : master holds req_i high; ack_o is high only in IDLE. The
//             command is taken on the first strobe in IDLE that sees the
//             synced req_i, at which point ack_o drops. The master must drop
//             req_i once it sees ack_o low, before the engine returns to IDLE.
//   status  : req_o is high only in FINISH and serial_status/cmd_out are
//             stable while it is high. The master raises ack_i; on a strobe
//             that sees the synced ack_i the engine returns to IDLE and req_o
//             drops. The master then drops ack_i.
// All FSM progress happens only on sd_clk_en strobes; go_idle_i is the single
// exception and takes effect on the next clock regardless of the strobe.
module sd_cmd_serial_host
    import sd_cmd_serial_host_pkg::*;
#(
    parameter int INIT_CLKS = 74,
    parameter int RESP_WAIT = 64
) (
    input  logic        CLK_PAD_IO,
    input  logic        RST_PAD_I,
    input  logic        sd_clk_en,
    input  logic        go_idle_i,
    input  logic [39:0] cmd_in,
    input  logic [15:0] settings_i,
    input  logic        req_i,
    output logic        ack_o,
    output logic        req_o,
    input  logic        ack_i,
    output logic [39:0] cmd_out,
    output logic [7:0]  serial_status,
    input  logic        cmd_dat_i,
    output logic        cmd_out_o,
    output logic        cmd_oe_o,
    output logic [6:0]  fsm_state
);

    localparam logic [7:0] INIT_LAST = 8'(INIT_CLKS - 1);
    localparam logic [7:0] RESP_LAST = 8'(RESP_WAIT - 1);

    state_t      state;
    state_t      next_state;

    logic        req_meta;
    logic        req_s;
    logic        ack_meta;
    logic        ack_s;

    logic [7:0]  cnt;
    logic        step;
    logic        accept;

    logic [39:0] tx_sh;
    logic [2:0]  dly_r;
    logic        crc_chk_r;
    logic [6:0]  size_r;
    logic [6:0]  crc_tx;
    logic        tx_crc_en;

    logic        resp_long;
    logic [7:0]  data_first;
    logic [7:0]  crc_first;
    logic [7:0]  last_bit;
    logic        rx_sample;
    logic [7:0]  rx_idx;
    logic        rx_crc_en;
    logic        rx_in_crc_field;
    logic [6:0]  crc_rx;
    logic [6:0]  rx_crc_field;
    logic        crc_ok;

    logic        dat_ava_r;
    logic        crc_valid_r;
    logic        busy;

    // rd/wr flags steer the data path elsewhere; the CMD line has no use for them.
    logic        unused_settings;
    assign unused_settings = ^settings_i[15:11];

    // Request and acknowledge synchronisers (2 flops each)
    always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
        if (RST_PAD_I) begin
            req_meta <= 1'b0;
            req_s    <= 1'b0;
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            req_meta <= req_i;
            req_s    <= req_meta;
            ack_meta <= ack_i;
            ack_s    <= ack_meta;
        end
    end

    assign step   = sd_clk_en && !go_idle_i;
    assign accept = step && (state == ST_IDLE) && req_s;

    // Response geometry selected by the latched size code
    assign resp_long  = (size_r == RESP_LONG);
    assign data_first = resp_long ? LONG_DATA_FIRST : SHORT_DATA_FIRST;
    assign crc_first  = resp_long ? LONG_CRC_FIRST  : SHORT_CRC_FIRST;
    assign last_bit   = resp_long ? LONG_LAST       : SHORT_LAST;

    // State register
    always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
        if (RST_PAD_I) begin
            state <= ST_INIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        next_state = state;
        ack_o      = 1'b0;
        req_o      = 1'b0;
        busy       = 1'b1;
        case (state)
            ST_INIT: begin
                busy = 1'b0;
                if (sd_clk_en && cnt == INIT_LAST) next_state = ST_IDLE;
            end
            ST_IDLE: begin
                busy  = 1'b0;
                ack_o = 1'b1;
                if (sd_clk_en && req_s) next_state = ST_WRITE;
            end
            ST_WRITE: begin
                if (sd_clk_en && cnt == CMD_LAST) next_state = ST_DLY;
            end
            ST_DLY: begin
                if (sd_clk_en && cnt == {5'd0, dly_r}) begin
                    next_state = (size_r == 7'd0) ? ST_FINISH : ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (sd_clk_en) begin
                    if (!cmd_dat_i) begin
                        next_state = ST_READ;
                    end else if (cnt >= RESP_LAST) begin
                        next_state = ST_FINISH;
                    end
                end
            end
            ST_READ: begin
                if (sd_clk_en && cnt == last_bit) next_state = ST_FINISH;
            end
            ST_FINISH: begin
                req_o = 1'b1;
                if (sd_clk_en && ack_s) next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
        if (go_idle_i) next_state = ST_IDLE;
    end

    assign fsm_state = state;

    // Shared bit counter: restarts on every state change, saturates otherwise.
    // Entering READ starts at 1 because the start bit was consumed in WAIT_RSP.
    always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
        if (RST_PAD_I) begin
            cnt <= 8'd0;
        end else if (go_idle_i) begin
            cnt <= 8'd0;
        end else if (sd_clk_en) begin
            if (next_state != state) begin
                cnt <= (next_state == ST_READ) ? 8'd1 : 8'd0;
            end else if (cnt != 8'hFF) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // Command latch and transmit shifter. After the 40 command bits the
    // remaining CRC bits and the end bit are reloaded into the top of the
    // shifter so the pin always takes tx_sh[39] except on the first CRC bit.
    always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
        if (RST_PAD_I) begin
            tx_sh     <= 40'd0;
            dly_r     <= 3'd0;
            crc_chk_r <= 1'b0;
            size_r    <= 7'd0;
        end else if (accept) begin
            tx_sh     <= cmd_in;
            dly_r     <= settings_i[10:8];
            crc_chk_r <= settings_i[7];
            size_r    <= settings_i[6:0];
        end else if (step && state == ST_WRITE) begin
            if (cnt == CMD_BITS) begin
                tx_sh <= {crc_tx[5:0], 1'b1, 33'd0};
            end else begin
                tx_sh <= {tx_sh[38:0], 1'b0};
            end
        end
    end

    assign tx_crc_en = step && (state == ST_WRITE) && (cnt < CMD_BITS);

    sd_crc7_serial u_crc_tx (
        .CLK_PAD_IO (CLK_PAD_IO),
        .RST_PAD_I  (RST_PAD_I),
        .bit_in     (tx_sh[39]),
        .enable     (tx_crc_en),
        .clear      (accept),
        .crc        (crc_tx)
    );

    // CMD pin driver: driven high when not transmitting, released while
    // waiting for and receiving the response.
    always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
        if (RST_PAD_I) begin
            cmd_out_o <= 1'b1;
            cmd_oe_o  <= 1'b1;
        end else if (go_idle_i) begin
            cmd_out_o <= 1'b1;
            cmd_oe_o  <= 1'b1;
        end else if (sd_clk_en) begin
            case (state)
                ST_WRITE: begin
                    cmd_oe_o  <= 1'b1;
                    cmd_out_o <= (cnt == CMD_BITS) ? crc_tx[6] : tx_sh[39];
                end
                ST_DLY, ST_WAIT_RSP, ST_READ: begin
                    cmd_oe_o  <= 1'b0;
                    cmd_out_o <= 1'b1;
                end
                default: begin
                    cmd_oe_o  <= 1'b1;
                    cmd_out_o <= 1'b1;
                end
            endcase
        end
    end

    // Receive side: the start bit is bit 0 and is sampled in WAIT_RSP;
    // the remaining bits are numbered by the counter in READ.
    assign rx_sample       = step && (((state == ST_WAIT_RSP) && !cmd_dat_i) || (state == ST_READ));
    assign rx_idx          = (state == ST_READ) ? cnt : 8'd0;
    assign rx_crc_en       = rx_sample && (rx_idx >= data_first) && (rx_idx < crc_first);
    assign rx_in_crc_field = (rx_idx >= crc_first) && (rx_idx < crc_first + 8'd7);

    sd_crc7_serial u_crc_rx (
        .CLK_PAD_IO (CLK_PAD_IO),
        .RST_PAD_I  (RST_PAD_I),
        .bit_in     (cmd_dat_i),
        .enable     (rx_crc_en),
        .clear      (accept),
        .crc        (crc_rx)
    );

    // Capture response bits 0..39 and the received CRC field
    always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
        if (RST_PAD_I) begin
            cmd_out      <= 40'd0;
            rx_crc_field <= 7'd0;
        end else if (accept) begin
            cmd_out      <= 40'd0;
            rx_crc_field <= 7'd0;
        end else if (rx_sample) begin
            if (rx_idx < CAPTURE_BITS) cmd_out <= {cmd_out[38:0], cmd_dat_i};
            if (rx_in_crc_field) rx_crc_field <= {rx_crc_field[5:0], cmd_dat_i};
        end
    end

    assign crc_ok = (rx_crc_field == crc_rx) || !crc_chk_r;

    // Status flags, set on the strobe that enters FINISH. With no response
    // expected there is no CRC that could fail, so crc_valid is reported set.
    always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
        if (RST_PAD_I) begin
            dat_ava_r   <= 1'b0;
            crc_valid_r <= 1'b0;
        end else if (accept) begin
            dat_ava_r   <= 1'b0;
            crc_valid_r <= 1'b0;
        end else if (step && next_state == ST_FINISH && state != ST_FINISH) begin
            case (state)
                ST_DLY: begin
                    dat_ava_r   <= 1'b1;
                    crc_valid_r <= 1'b1;
                end
                ST_READ: begin
                    dat_ava_r   <= 1'b1;
                    crc_valid_r <= crc_ok;
                end
                default: begin
                    dat_ava_r   <= 1'b0;
                    crc_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Status byte assembly
    always_comb begin
        serial_status                   = 8'd0;
        serial_status[STATUS_DAT_AVA]   = dat_ava_r;
        serial_status[STATUS_CRC_VALID] = crc_valid_r;
        serial_status[STATUS_BUSY]      = busy;
    end

endmodule
